// File: rtl/osd_cmd_arbiter_if.sv
// rtl/osd_cmd_arbiter_if.sv - requester-side and OSD-side signal bundle for osd_cmd_arbiter
interface osd_cmd_arbiter_if;
  logic [1:0]  rq_req;
  logic [1:0]  rq_gnt;
  logic [1:0]  rq_valid;
  logic [1:0]  rq_last;
  logic [15:0] rq_din0;
  logic [15:0] rq_din1;
  logic [1:0]  rq_ready;
  logic        io_osd;
  logic        io_strobe;
  logic [15:0] io_din;

  modport master (
    output rq_req, rq_valid, rq_last, rq_din0, rq_din1,
    input  rq_gnt, rq_ready, io_osd, io_strobe, io_din
  );

  modport slave (
    input  rq_req, rq_valid, rq_last, rq_din0, rq_din1,
    output rq_gnt, rq_ready, io_osd, io_strobe, io_din
  );
endinterface

// File: rtl/osd_cmd_arbiter.sv
// rtl/osd_cmd_arbiter.sv - two-port round-robin OSD command bus arbiter with strobe timing
// Optional stall timeout: OSD_ARB_TIMEOUT_EN
module osd_cmd_arbiter #(
  parameter int STB_HI  = 2,
  parameter int STB_LO  = 2,
  parameter int REL_GAP = 4,
  parameter int TIMEOUT = 1024
) (
  input  logic             clk_sys,
  input  logic             reset,
  osd_cmd_arbiter_if.slave bus,
  output logic             osd_on,
  output logic             busy
`ifdef OSD_ARB_TIMEOUT_EN
  ,
  output logic             timeout_err
`endif
);

  // One counter serves strobe phases, the release gap and the WAIT stall timer.
  localparam int MAX_A = (STB_HI > STB_LO) ? STB_HI : STB_LO;
  localparam int MAX_B = (REL_GAP > TIMEOUT) ? REL_GAP : TIMEOUT;
  localparam int MAXP  = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int CW    = $clog2(MAXP) + 1;

  typedef enum logic [2:0] {IDLE, WAIT, STB_H, STB_L, REL} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [1:0]    gnt;
  logic          last_srv;
  logic          last_flag;
  logic          first_flag;
  logic          osd_r;
  logic [15:0]   din_r;

  logic          win_idx;
  logic [1:0]    win;
  logic          accept;
  logic [15:0]   word;
  logic          word_last;

  assign win_idx   = (bus.rq_req == 2'b11) ? ~last_srv : bus.rq_req[1];
  assign win       = win_idx ? 2'b10 : 2'b01;
  assign accept    = (state == WAIT) && (|(bus.rq_valid & gnt));
  assign word      = gnt[1] ? bus.rq_din1 : bus.rq_din0;
  assign word_last = |(bus.rq_last & gnt);

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      IDLE: begin
        if (|bus.rq_req) begin
          state_nxt = WAIT;
          cnt_nxt   = '0;
        end
      end
      WAIT: begin
        if (accept) begin
          state_nxt = STB_H;
          cnt_nxt   = CW'(STB_HI - 1);
        end
`ifdef OSD_ARB_TIMEOUT_EN
        else if (cnt == CW'(TIMEOUT - 1)) begin
          state_nxt = REL;
          cnt_nxt   = CW'(REL_GAP - 1);
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
`endif
      end
      STB_H: begin
        if (cnt == '0) begin
          state_nxt = STB_L;
          cnt_nxt   = CW'(STB_LO - 1);
        end else begin
          cnt_nxt = cnt - CW'(1);
        end
      end
      STB_L: begin
        if (cnt == '0) begin
          if (last_flag) begin
            state_nxt = REL;
            cnt_nxt   = CW'(REL_GAP - 1);
          end else begin
            state_nxt = WAIT;
            cnt_nxt   = '0;
          end
        end else begin
          cnt_nxt = cnt - CW'(1);
        end
      end
      REL: begin
        if (cnt == '0) begin
          state_nxt = IDLE;
        end else begin
          cnt_nxt = cnt - CW'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      gnt        <= '0;
      osd_r      <= 1'b0;
      din_r      <= '0;
      osd_on     <= 1'b0;
      last_srv   <= 1'b1;
      last_flag  <= 1'b0;
      first_flag <= 1'b0;
    end else begin
      if (state == IDLE && (|bus.rq_req)) begin
        gnt        <= win;
        osd_r      <= 1'b1;
        last_srv   <= win_idx;
        first_flag <= 1'b1;
      end
      if (accept) begin
        din_r      <= word;
        last_flag  <= word_last;
        first_flag <= 1'b0;
        // Only the command word of a transaction can toggle the shadow enable.
        if (first_flag && word[7:4] == 4'h4) begin
          osd_on <= word[0];
        end
      end
      if (state != REL && state_nxt == REL) begin
        gnt   <= '0;
        osd_r <= 1'b0;
      end
    end
  end

`ifdef OSD_ARB_TIMEOUT_EN
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      timeout_err <= 1'b0;
    end else if (state == WAIT && state_nxt == REL) begin
      timeout_err <= 1'b1;
    end
  end
`endif

  assign bus.rq_gnt    = gnt;
  assign bus.rq_ready  = (state == WAIT) ? gnt : 2'b00;
  assign bus.io_osd    = osd_r;
  assign bus.io_strobe = (state == STB_H);
  assign bus.io_din    = din_r;
  assign busy          = (state != IDLE);

endmodule

// File: tb/tb_osd_cmd_arbiter.sv
// tb/tb_osd_cmd_arbiter.sv - randomized bench for osd_cmd_arbiter checked against a transaction schedule model
module tb_osd_cmd_arbiter;
  localparam int HI   = 2;
  localparam int LO   = 2;
  localparam int GAP  = 4;
  localparam int TMO  = 16;
  localparam int MAXC = 512;

  logic clk_sys = 1'b0;
  logic reset;
  logic osd_on;
  logic busy;
`ifdef OSD_ARB_TIMEOUT_EN
  logic timeout_err;
`endif

  osd_cmd_arbiter_if bus();

  osd_cmd_arbiter #(.STB_HI(HI), .STB_LO(LO), .REL_GAP(GAP), .TIMEOUT(TMO)) dut (
    .clk_sys(clk_sys),
    .reset  (reset),
    .bus    (bus),
    .osd_on (osd_on),
    .busy   (busy)
`ifdef OSD_ARB_TIMEOUT_EN
    ,
    .timeout_err(timeout_err)
`endif
  );

  always #5 clk_sys = ~clk_sys;

  int nchk = 0;
  int nfail = 0;

  logic [15:0] wd [2][8];
  int          dl [2][8];
  int          nw [2];
  int          idx [2];
  int          next_v [2];
  bit          done [2];

  logic [1:0]  exp_gnt  [MAXC];
  logic [1:0]  exp_rdy  [MAXC];
  logic        exp_osd  [MAXC];
  logic        exp_stb  [MAXC];
  logic        exp_busy [MAXC];
  logic        exp_on   [MAXC];
  logic [15:0] exp_din  [MAXC];
  logic [1:0]  act_gnt  [MAXC];

  logic        m_last;
  logic [15:0] m_din;
  logic        m_on;

  bit   chk_on = 1'b0;
  int   cyc = 0;
  int   st_rises = 0;
  logic prev_stb = 1'b0;

  task automatic check(input string nm, input logic [15:0] act, input logic [15:0] exp);
    nchk++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s t=%0t got %h expected %h", nm, $time, act, exp);
    end
  endtask

  // Schedule model: word i is accepted at max(ready rise, valid rise); every word
  // then costs HI strobe-high plus LO strobe-low cycles; a transaction is followed
  // by GAP release cycles and one idle cycle before the next grant is visible.
  task automatic build_model(input logic [1:0] req, output int len);
    int order [2];
    int ns, t, g, rr, v, a, e, p;
    for (int c = 0; c < MAXC; c++) begin
      exp_gnt[c] = 2'b00; exp_rdy[c] = 2'b00; exp_osd[c] = 1'b0; exp_stb[c] = 1'b0;
      exp_busy[c] = 1'b0; exp_din[c] = m_din; exp_on[c] = m_on;
    end
    if (req == 2'b11) begin
      order[0] = m_last ? 0 : 1;
      order[1] = 1 - order[0];
      ns = 2;
    end else begin
      order[0] = req[1] ? 1 : 0;
      order[1] = 0;
      ns = 1;
    end
    t = 1;
    a = 0;
    for (int k = 0; k < ns; k++) begin
      p = order[k];
      m_last = (p == 1);
      g = t;
      rr = g;
      for (int i = 0; i < nw[p]; i++) begin
        v = (i == 0) ? dl[p][0] : a + 1 + dl[p][i];
        a = (v > rr) ? v : rr;
        for (int c = rr; c <= a; c++) exp_rdy[c][p] = 1'b1;
        for (int c = a + 1; c <= a + HI; c++) exp_stb[c] = 1'b1;
        for (int c = a + 1; c < MAXC; c++) exp_din[c] = wd[p][i];
        if (i == 0 && wd[p][0][7:4] == 4'h4)
          for (int c = a + 1; c < MAXC; c++) exp_on[c] = wd[p][0][0];
        rr = a + 1 + HI + LO;
      end
      e = a + HI + LO;
      for (int c = g; c <= e; c++) begin
        exp_gnt[c] = (p == 0) ? 2'b01 : 2'b10;
        exp_osd[c] = 1'b1;
      end
      for (int c = g; c <= e + GAP; c++) exp_busy[c] = 1'b1;
      t = e + GAP + 2;
    end
    len = t;
    m_din = exp_din[len-1];
    m_on = exp_on[len-1];
  endtask

  task automatic drive(input int c);
    logic [1:0]  rq, v, l;
    logic [15:0] d [2];
    for (int p = 0; p < 2; p++) begin
      rq[p] = !done[p];
      v[p]  = !done[p] && (c >= next_v[p]);
      l[p]  = v[p] ? (idx[p] == nw[p] - 1) : 1'($urandom);
      d[p]  = v[p] ? wd[p][idx[p]] : 16'($urandom);
    end
    bus.rq_req   = rq;
    bus.rq_valid = v;
    bus.rq_last  = l;
    bus.rq_din0  = d[0];
    bus.rq_din1  = d[1];
  endtask

  task automatic take(input int c);
    for (int p = 0; p < 2; p++) begin
      if (!done[p] && bus.rq_valid[p] && bus.rq_ready[p]) begin
        if (idx[p] == nw[p] - 1) begin
          done[p] = 1'b1;
        end else begin
          idx[p]++;
          next_v[p] = c + 1 + dl[p][idx[p]];
        end
      end
    end
  endtask

  task automatic begin_scn(input logic [1:0] req);
    for (int p = 0; p < 2; p++) begin
      idx[p] = 0;
      done[p] = !req[p];
      next_v[p] = dl[p][0];
    end
  endtask

  task automatic zero_dl();
    for (int p = 0; p < 2; p++)
      for (int i = 0; i < 8; i++) dl[p][i] = 0;
  endtask

  task automatic run_scn(input logic [1:0] req);
    int len;
    build_model(req, len);
    begin_scn(req);
    st_rises = 0;
    cyc = 0;
    drive(0);
    chk_on = 1'b1;
    for (int c = 0; c < len; c++) begin
      @(negedge clk_sys);
      take(c);
      @(posedge clk_sys);
      #1;
      cyc = c + 1;
      drive(c + 1);
    end
    chk_on = 1'b0;
  endtask

  always @(negedge clk_sys) begin
    if (chk_on) begin
      check("rq_gnt",    16'(bus.rq_gnt),    16'(exp_gnt[cyc]));
      check("rq_ready",  16'(bus.rq_ready),  16'(exp_rdy[cyc]));
      check("io_osd",    16'(bus.io_osd),    16'(exp_osd[cyc]));
      check("io_strobe", 16'(bus.io_strobe), 16'(exp_stb[cyc]));
      check("io_din",    bus.io_din,         exp_din[cyc]);
      check("osd_on",    16'(osd_on),        16'(exp_on[cyc]));
      check("busy",      16'(busy),          16'(exp_busy[cyc]));
      act_gnt[cyc] = bus.rq_gnt;
      if (bus.io_strobe && !prev_stb) st_rises++;
    end
    prev_stb = bus.io_strobe;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog t=%0t got timeout expected finish", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    bus.rq_req = 2'b00; bus.rq_valid = 2'b00; bus.rq_last = 2'b00;
    bus.rq_din0 = '0; bus.rq_din1 = '0;
    m_last = 1'b1; m_din = '0; m_on = 1'b0;
    for (int p = 0; p < 2; p++) begin
      nw[p] = 1;
      for (int i = 0; i < 8; i++) begin wd[p][i] = '0; dl[p][i] = 0; end
    end
    repeat (3) @(posedge clk_sys);
    #1;
    reset = 1'b0;

    for (int c = 0; c < 10; c++) begin
      @(negedge clk_sys);
      check("idle_gnt",  16'(bus.rq_gnt), 16'h0);
      check("idle_rdy",  16'(bus.rq_ready), 16'h0);
      check("idle_osd",  16'(bus.io_osd), 16'h0);
      check("idle_stb",  16'(bus.io_strobe), 16'h0);
      check("idle_din",  bus.io_din, 16'h0);
      check("idle_on",   16'(osd_on), 16'h0);
      check("idle_busy", 16'(busy), 16'h0);
    end
    @(posedge clk_sys);
    #1;

    for (int r = 0; r < 2; r++) begin
      zero_dl();
      nw[0] = 1; nw[1] = 1;
      wd[0][0] = 16'h0031; wd[1][0] = 16'h0032;
      run_scn(2'b11);
      check("rr_first_gnt",  16'(act_gnt[1]),  16'h1);
      check("rr_gap_gnt",    16'(act_gnt[10]), 16'h0);
      check("rr_second_gnt", 16'(act_gnt[11]), 16'h2);
    end

    zero_dl();
    nw[0] = 3;
    wd[0][0] = 16'h0041; wd[0][1] = 16'h0010; wd[0][2] = 16'h0020;
    run_scn(2'b01);
    check("t2_rises",      16'(st_rises), 16'd3);
    check("t2_osd_on",     16'(osd_on), 16'h1);
    check("t2_mdl_gnt1",   16'(exp_gnt[1]), 16'h1);
    check("t2_mdl_stb12",  16'(exp_stb[12]), 16'h1);
    check("t2_mdl_stb14",  16'(exp_stb[14]), 16'h0);
    check("t2_mdl_din12",  exp_din[12], 16'h0020);
    check("t2_mdl_osd15",  16'(exp_osd[15]), 16'h1);
    check("t2_mdl_osd16",  16'(exp_osd[16]), 16'h0);
    check("t2_mdl_busy19", 16'(exp_busy[19]), 16'h1);
    check("t2_mdl_busy20", 16'(exp_busy[20]), 16'h0);

    nw[0] = 1;
    wd[0][0] = 16'h0040;
    run_scn(2'b01);
    check("t4_osd_off", 16'(osd_on), 16'h0);
    nw[1] = 5;
    wd[1][0] = 16'h0020; wd[1][1] = 16'h0041; wd[1][2] = 16'h0141;
    wd[1][3] = 16'h1234; wd[1][4] = 16'h0043;
    run_scn(2'b10);
    check("t4_rises",     16'(st_rises), 16'd5);
    check("t4_osd_keep",  16'(osd_on), 16'h0);

    for (int s = 0; s < 40; s++) begin
      for (int p = 0; p < 2; p++) begin
        nw[p] = $urandom_range(1, 5);
        for (int i = 0; i < 8; i++) begin
          wd[p][i] = 16'($urandom);
          dl[p][i] = $urandom_range(0, 6);
        end
        dl[p][0] = $urandom_range(0, 8);
        if ($urandom_range(0, 1) == 1) wd[p][0][7:4] = 4'h4;
      end
      run_scn(2'($urandom_range(1, 3)));
    end

    zero_dl();
    nw[0] = 3;
    wd[0][0] = 16'h0041; wd[0][1] = 16'hAAAA; wd[0][2] = 16'h5555;
    begin_scn(2'b01);
    drive(0);
    for (int c = 0; c < 7; c++) begin
      @(negedge clk_sys);
      take(c);
      @(posedge clk_sys);
      #1;
      drive(c + 1);
    end
    @(negedge clk_sys);
    check("t5_pre_stb", 16'(bus.io_strobe), 16'h1);
    check("t5_pre_din", bus.io_din, 16'hAAAA);
    reset = 1'b1;
    @(posedge clk_sys);
    #1;
    check("t5_osd",  16'(bus.io_osd), 16'h0);
    check("t5_stb",  16'(bus.io_strobe), 16'h0);
    check("t5_gnt",  16'(bus.rq_gnt), 16'h0);
    check("t5_busy", 16'(busy), 16'h0);
    check("t5_on",   16'(osd_on), 16'h0);
    reset = 1'b0;
    m_last = 1'b1; m_din = '0; m_on = 1'b0;
    nw[1] = 2;
    wd[1][0] = 16'h0051; wd[1][1] = 16'h0F0F;
    run_scn(2'b10);

`ifdef OSD_ARB_TIMEOUT_EN
    reset = 1'b1;
    @(posedge clk_sys);
    #1;
    reset = 1'b0;
    zero_dl();
    nw[0] = 1; nw[1] = 1;
    dl[0][0] = 100000;
    wd[0][0] = 16'h0011; wd[1][0] = 16'h0022;
    begin_scn(2'b11);
    drive(0);
    for (int c = 0; c < 26; c++) begin
      @(negedge clk_sys);
      if (c == 16) begin
        check("tmo_err_pre", 16'(timeout_err), 16'h0);
        check("tmo_gnt_pre", 16'(bus.rq_gnt), 16'h1);
      end
      if (c == 17) begin
        check("tmo_err",  16'(timeout_err), 16'h1);
        check("tmo_gnt",  16'(bus.rq_gnt), 16'h0);
        check("tmo_osd",  16'(bus.io_osd), 16'h0);
        check("tmo_busy", 16'(busy), 16'h1);
      end
      if (c == 22) check("tmo_next_gnt", 16'(bus.rq_gnt), 16'h2);
      take(c);
      @(posedge clk_sys);
      #1;
      drive(c + 1);
    end
    reset = 1'b1;
    @(posedge clk_sys);
    #1;
    check("tmo_err_clr", 16'(timeout_err), 16'h0);
    reset = 1'b0;
    bus.rq_req = 2'b00;
    bus.rq_valid = 2'b00;
`endif

    $display("[TB] %0d tests run, %0d failed", nchk, nfail);
    $finish;
  end
endmodule
